traffic_gen_chk: RTL and testbench
==================================

TRAFFIC_GEN_CHK -- requirements
Module: traffic_gen_chk

Interface
REQ-001 Parameters (name, default, meaning): NUM_CH, 2, channel count, legal 1..8.
REQ-002 DATA_W, 8, bits per channel, legal 4..16.
REQ-003 SEED, 16'hACE1, LFSR base seed; must be nonzero.
REQ-004 Ports (name direction width meaning): clk_2f in 1 sole clock, all logic on rising edge.
REQ-005 reset in 1: asynchronous, active-high; asserting it clears all state immediately; release is sampled on clk_2f.
REQ-006 start in 1: one-cycle request to begin a run; honoured only in IDLE or DONE.
REQ-007 mode in 2: pattern select, 0 incrementing, 1 walking-one, 2 LFSR, 3 reserved (treated as 0).
REQ-008 burst_len in 8: beats per burst. gap_len in 8: idle cycles between bursts. num_bursts in 8: bursts per run.
REQ-009 data_out out NUM_CH*DATA_W: generated data, channel c in bits [c*DATA_W +: DATA_W].
REQ-010 valid_out out NUM_CH: per-channel valid toward the DUT.
REQ-011 data_in in NUM_CH*DATA_W and valid_in in NUM_CH: returned DUT data, same packing.
REQ-012 busy out 1, done out 1, timeout out 1, err_count out 16, rx_count out 16, mismatch_ch out NUM_CH (sticky per-channel error flag).

Function
REQ-013 FSM states IDLE, BURST, GAP, DRAIN, DONE; all outputs registered.
REQ-014 IDLE/DONE + start: latch mode, burst_len, gap_len, num_bursts; clear err_count, rx_count, mismatch_ch, timeout, done; reseed generators and checkers; go BURST; first valid_out high on the edge after start is sampled.
REQ-015 start with burst_len=0 or num_bursts=0: go DONE in one cycle, counters zero, no valid_out.
REQ-016 BURST: all valid_out bits high for exactly burst_len consecutive cycles; each generator advances once per beat.
REQ-017 End of burst: bursts remaining and gap_len>0 -> GAP for gap_len cycles, valid_out=0; bursts remaining and gap_len=0 -> next burst back-to-back; last burst -> DRAIN.
REQ-018 When valid_out is low, data_out holds its last value.
REQ-019 Pattern per channel c: mode 0 starts at c and adds 1 mod 2^DATA_W; mode 1 starts with bit (c mod DATA_W) set and rotates left 1; mode 2 is a 16-bit Galois LFSR (taps 0xB400) seeded SEED^(c+1), output low DATA_W bits.
REQ-020 Checker per channel: independent copy of the generator; on each valid_in[c] compare data_in slice with expected, then advance. The DUT may add any latency but must not reorder or drop beats.
REQ-021 Mismatch: err_count +1 per mismatching channel beat, saturating at 16'hFFFF; mismatch_ch[c] set and held until next start.
REQ-022 rx_count adds popcount(valid_in) each cycle while busy, saturating at 16'hFFFF; valid_in ignored in IDLE/DONE.
REQ-023 DRAIN: leave for DONE when rx_count >= burst_len*num_bursts*NUM_CH, or after 255 DRAIN cycles; the timeout path sets timeout=1.
REQ-024 busy=1 in BURST, GAP, DRAIN; done=1 only in DONE; start while busy is ignored.
REQ-025 Multiple channels mismatching in the same cycle add their full count to err_count in that cycle.

Reset
REQ-026 While reset=1: state IDLE, data_out=0, valid_out=0, busy=0, done=0, timeout=0, err_count=0, rx_count=0, mismatch_ch=0, generators at seed values.
REQ-027 Reset mid-run: abort immediately, no partial done; after release, wait for a new start.

Verification
REQ-028 Loopback (data_in=data_out, valid_in=valid_out), NUM_CH=2, DATA_W=8, mode 0, burst_len=4, gap_len=2, num_bursts=2 -> ch0 sends 00..07, ch1 sends 01..08, gaps of 2 cycles, rx_count=16, err_count=0, done=1, timeout=0.
REQ-029 Same setup with 3-cycle delayed loopback, mode 2 -> err_count=0, rx_count=16, DRAIN exits on count.
REQ-030 Loopback with data_in ch1 bit0 forced to 1, mode 0, burst_len=4, num_bursts=1 -> ch1 expected 01,02,03,04, so the beats 02 and 04 mismatch; err_count=2, mismatch_ch=2'b10.
REQ-031 valid_in tied 0, burst_len=3, num_bursts=1 -> DRAIN for 255 cycles, then done=1, timeout=1, rx_count=0.
REQ-032 Assert reset in the middle of BURST -> valid_out=0 and busy=0 with no clock edge; start after release restarts from seed (ch0 data 00).
REQ-033 start with num_bursts=0 -> done=1 on the next edge, no valid_out pulse; start while busy -> no effect on the current run.

Source files
------------

// File: rtl/traffic_gen_chk.sv
// Multi-channel burst traffic generator with a matching in-order checker per channel.
// The generator drives bursts separated by gaps; the checker scores returned beats.
module traffic_gen_chk #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DATA_W = 8,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic                     clk_2f,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [7:0]               burst_len,
  input  logic [7:0]               gap_len,
  input  logic [7:0]               num_bursts,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        valid_out,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic [NUM_CH-1:0]        valid_in,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout,
  output logic [15:0]              err_count,
  output logic [15:0]              rx_count,
  output logic [NUM_CH-1:0]        mismatch_ch
);

  typedef enum logic [2:0] {S_IDLE, S_BURST, S_GAP, S_DRAIN, S_DONE} state_t;

  localparam logic [15:0] MASK = 16'((32'd1 << DATA_W) - 32'd1);

  state_t state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  burst_len_q, burst_len_d, gap_len_q, gap_len_d, num_bursts_q, num_bursts_d;
  logic [7:0]  beats_left_q, beats_left_d, bursts_left_q, bursts_left_d;
  logic [7:0]  gap_left_q, gap_left_d, drain_cnt_q, drain_cnt_d;
  logic [NUM_CH-1:0][15:0] gen_q, gen_d, chk_q, chk_d, gen_rst_s;
  logic [NUM_CH*DATA_W-1:0] data_out_q, data_out_d;
  logic [NUM_CH-1:0] valid_out_q, valid_out_d, mismatch_q, mismatch_d, mism_s;
  logic        busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
  logic [15:0] err_q, err_d, rx_q, rx_d, rx_inc_s, err_inc_s, cur_s;
  logic [19:0] target_s;
  logic        start_acc_s, busy_s, issue_s;

  // Initial pattern value of channel c for pattern mode m.
  function automatic logic [15:0] seed_f(input logic [1:0] m, input int unsigned c);
    logic [15:0] s;
    case (m)
      2'd1:    s = 16'd1 << (c % DATA_W);
      2'd2:    s = SEED ^ 16'(c + 32'd1);
      default: s = 16'(c) & MASK;
    endcase
    return s;
  endfunction

  // One pattern step: increment, rotate-left within DATA_W, or Galois LFSR shift.
  function automatic logic [15:0] next_f(input logic [1:0] m, input logic [15:0] s);
    logic [15:0] n;
    case (m)
      2'd1:    n = ((s << 1) | (s >> (DATA_W - 1))) & MASK;
      2'd2:    n = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
      default: n = (s + 16'd1) & MASK;
    endcase
    return n;
  endfunction

  function automatic logic [15:0] sat_add_f(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign busy_s   = (state_q == S_BURST) || (state_q == S_GAP) || (state_q == S_DRAIN);
  assign target_s = 20'(burst_len_q) * 20'(num_bursts_q) * 20'(NUM_CH);

  // Run sequencing: burst/gap/drain counters and state transitions.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    burst_len_d   = burst_len_q;
    gap_len_d     = gap_len_q;
    num_bursts_d  = num_bursts_q;
    beats_left_d  = beats_left_q;
    bursts_left_d = bursts_left_q;
    gap_left_d    = gap_left_q;
    drain_cnt_d   = drain_cnt_q;
    timeout_d     = timeout_q;
    start_acc_s   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          start_acc_s   = 1'b1;
          mode_d        = (mode == 2'd3) ? 2'd0 : mode;
          burst_len_d   = burst_len;
          gap_len_d     = gap_len;
          num_bursts_d  = num_bursts;
          beats_left_d  = burst_len;
          bursts_left_d = num_bursts;
          timeout_d     = 1'b0;
          state_d       = ((burst_len == 8'd0) || (num_bursts == 8'd0)) ? S_DONE : S_BURST;
        end else begin
          state_d = state_q;
        end
      end
      S_BURST: begin
        if (beats_left_q > 8'd1) begin
          beats_left_d = beats_left_q - 8'd1;
        end else if (bursts_left_q <= 8'd1) begin
          state_d     = S_DRAIN;
          drain_cnt_d = 8'd0;
        end else begin
          bursts_left_d = bursts_left_q - 8'd1;
          beats_left_d  = burst_len_q;
          if (gap_len_q != 8'd0) begin
            state_d    = S_GAP;
            gap_left_d = gap_len_q;
          end else begin
            state_d = S_BURST;
          end
        end
      end
      S_GAP: begin
        if (gap_left_q <= 8'd1) begin
          state_d = S_BURST;
        end else begin
          gap_left_d = gap_left_q - 8'd1;
        end
      end
      S_DRAIN: begin
        if ({4'd0, rx_q} >= target_s) begin
          state_d = S_DONE;
        end else if (drain_cnt_q == 8'd254) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign issue_s = (state_d == S_BURST);

  // Per-channel generators and checkers; a start reseeds both with the new mode.
  always_comb begin
    gen_rst_s  = '0;
    gen_d      = gen_q;
    chk_d      = chk_q;
    data_out_d = data_out_q;
    mism_s     = '0;
    rx_inc_s   = 16'd0;
    err_inc_s  = 16'd0;
    cur_s      = 16'd0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      gen_rst_s[c] = seed_f(2'd0, c);
      cur_s = start_acc_s ? seed_f(mode_d, c) : gen_q[c];
      if (issue_s) begin
        data_out_d[c*DATA_W +: DATA_W] = cur_s[DATA_W-1:0];
        gen_d[c] = next_f(mode_d, cur_s);
      end else begin
        gen_d[c] = cur_s;
      end
      if (start_acc_s) begin
        chk_d[c] = seed_f(mode_d, c);
      end else if (busy_s && valid_in[c]) begin
        rx_inc_s = rx_inc_s + 16'd1;
        if (data_in[c*DATA_W +: DATA_W] != chk_q[c][DATA_W-1:0]) begin
          mism_s[c] = 1'b1;
          err_inc_s = err_inc_s + 16'd1;
        end else begin
          mism_s[c] = 1'b0;
        end
        chk_d[c] = next_f(mode_q, chk_q[c]);
      end else begin
        chk_d[c] = chk_q[c];
      end
    end
  end

  // Status outputs follow the next state so they are registered with it.
  always_comb begin
    valid_out_d = {NUM_CH{issue_s}};
    busy_d      = (state_d == S_BURST) || (state_d == S_GAP) || (state_d == S_DRAIN);
    done_d      = (state_d == S_DONE);
    if (start_acc_s) begin
      rx_d       = 16'd0;
      err_d      = 16'd0;
      mismatch_d = '0;
    end else begin
      rx_d       = sat_add_f(rx_q, rx_inc_s);
      err_d      = sat_add_f(err_q, err_inc_s);
      mismatch_d = mismatch_q | mism_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mode_q        <= 2'd0;
      burst_len_q   <= 8'd0;
      gap_len_q     <= 8'd0;
      num_bursts_q  <= 8'd0;
      beats_left_q  <= 8'd0;
      bursts_left_q <= 8'd0;
      gap_left_q    <= 8'd0;
      drain_cnt_q   <= 8'd0;
      gen_q         <= gen_rst_s;
      chk_q         <= gen_rst_s;
      data_out_q    <= '0;
      valid_out_q   <= '0;
      mismatch_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      err_q         <= 16'd0;
      rx_q          <= 16'd0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      burst_len_q   <= burst_len_d;
      gap_len_q     <= gap_len_d;
      num_bursts_q  <= num_bursts_d;
      beats_left_q  <= beats_left_d;
      bursts_left_q <= bursts_left_d;
      gap_left_q    <= gap_left_d;
      drain_cnt_q   <= drain_cnt_d;
      gen_q         <= gen_d;
      chk_q         <= chk_d;
      data_out_q    <= data_out_d;
      valid_out_q   <= valid_out_d;
      mismatch_q    <= mismatch_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      err_q         <= err_d;
      rx_q          <= rx_d;
    end
  end

  assign data_out    = data_out_q;
  assign valid_out   = valid_out_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign err_count   = err_q;
  assign rx_count    = rx_q;
  assign mismatch_ch = mismatch_q;

endmodule

// File: tb/tb_traffic_gen_chk.sv
// Bench for traffic_gen_chk (2 channels x 8 bits): loopback with optional delay,
// bit forcing or a dead return path, scored against a pattern model.
module tb_traffic_gen_chk;

  logic        clk_2f, reset, start;
  logic [1:0]  mode;
  logic [7:0]  burst_len, gap_len, num_bursts;
  logic [15:0] data_out, data_in;
  logic [1:0]  valid_out, valid_in, mismatch_ch;
  logic        busy, done, timeout;
  logic [15:0] err_count, rx_count;

  int checks = 0;
  int errors = 0;

  int          lb_delay;
  bit          lb_en;
  logic [15:0] force_mask;
  logic [15:0] dpipe [3];
  logic [1:0]  vpipe [3];
  logic [15:0] d_s;
  logic [1:0]  v_s;

  logic [15:0] sent_q[$];
  logic [1:0]  vpat[$];
  int          busy_cycles, hold_bad;
  bit          run_done;

  traffic_gen_chk dut (
    .clk_2f(clk_2f), .reset(reset), .start(start), .mode(mode),
    .burst_len(burst_len), .gap_len(gap_len), .num_bursts(num_bursts),
    .data_out(data_out), .valid_out(valid_out), .data_in(data_in), .valid_in(valid_in),
    .busy(busy), .done(done), .timeout(timeout), .err_count(err_count),
    .rx_count(rx_count), .mismatch_ch(mismatch_ch)
  );

  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  // Return path: a fixed-depth delay line, optional forced bits, optional cut.
  always @(posedge clk_2f) begin
    dpipe[0] <= data_out;  vpipe[0] <= valid_out;
    dpipe[1] <= dpipe[0];  vpipe[1] <= vpipe[0];
    dpipe[2] <= dpipe[1];  vpipe[2] <= vpipe[1];
  end

  always_comb begin
    d_s = data_out;
    v_s = valid_out;
    case (lb_delay)
      1: begin d_s = dpipe[0]; v_s = vpipe[0]; end
      2: begin d_s = dpipe[1]; v_s = vpipe[1]; end
      3: begin d_s = dpipe[2]; v_s = vpipe[2]; end
      default: ;
    endcase
    data_in  = d_s | force_mask;
    valid_in = lb_en ? v_s : 2'b00;
  end

  // Expected k-th beat (0-based) on channel c for a given mode.
  function automatic logic [7:0] exp_val(input logic [1:0] m, input int c, input int k);
    logic [15:0] s;
    if (m == 2'd1) begin
      s = 16'd1 << ((c + k) % 8);
    end else if (m == 2'd2) begin
      s = 16'hACE1 ^ 16'(c + 1);
      for (int j = 0; j < k; j++) s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    end else begin
      s = 16'(c + k);
    end
    return s[7:0];
  endfunction

  // Number of sampled cycles whose valid_out differs from the burst/gap schedule.
  function automatic int pattern_errs(input int bl, input int gl, input int nb);
    logic [1:0] e[$];
    logic [1:0] ev;
    int n;
    n = 0;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < bl; j++) e.push_back(2'b11);
      if (b < nb - 1) for (int j = 0; j < gl; j++) e.push_back(2'b00);
    end
    for (int i = 0; i < vpat.size(); i++) begin
      ev = (i < e.size()) ? e[i] : 2'b00;
      if (vpat[i] !== ev) n++;
    end
    if (vpat.size() < e.size()) n += e.size() - vpat.size();
    return n;
  endfunction

  function automatic int data_errs(input logic [1:0] m);
    logic [15:0] w;
    int n;
    n = 0;
    for (int k = 0; k < sent_q.size(); k++) begin
      w = sent_q[k];
      if (w[7:0]  !== exp_val(m, 0, k)) n++;
      if (w[15:8] !== exp_val(m, 1, k)) n++;
    end
    return n;
  endfunction

  // Start a run and record what the generator emits until done or the budget expires.
  task automatic do_run(input logic [1:0] m, input int bl, input int gl, input int nb,
                        input int budget, input int poke_at);
    logic [15:0] last;
    bit have;
    sent_q.delete(); vpat.delete();
    busy_cycles = 0; hold_bad = 0; run_done = 0; have = 0; last = 16'd0;
    @(negedge clk_2f);
    mode = m; burst_len = 8'(bl); gap_len = 8'(gl); num_bursts = 8'(nb); start = 1'b1;
    @(negedge clk_2f);
    start = 1'b0;
    for (int i = 0; i < budget; i++) begin
      vpat.push_back(valid_out);
      if (valid_out != 2'b00) begin
        if (valid_out != 2'b11) hold_bad++;
        sent_q.push_back(data_out);
        last = data_out;
        have = 1;
      end else if (have && data_out != last) begin
        hold_bad++;
      end
      if (busy) busy_cycles++;
      if (done) begin
        run_done = 1;
        break;
      end
      if (i == poke_at) begin
        start = 1'b1; mode = 2'd1; burst_len = 8'd1; gap_len = 8'd0; num_bursts = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk_2f);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_2f);
    checks++;
    if ({data_out, valid_out, busy, done, timeout, err_count, rx_count, mismatch_ch} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h valid=%b busy=%b done=%b to=%b err=%0d rx=%0d mis=%b, expected all zero",
               data_out, valid_out, busy, done, timeout, err_count, rx_count, mismatch_ch);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk_2f);
    checks++;
    if ({busy, done, valid_out} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b valid=%b expected 0 0 00", busy, done, valid_out);
    end
  endtask

  task automatic test_loopback_inc();
    lb_en = 1; lb_delay = 0; force_mask = 16'h0000;
    do_run(2'd0, 4, 2, 2, 300, -1);
    checks++;
    if (!run_done) begin errors++; $display("FAIL loop_done: done never seen within budget"); end
    checks++;
    if (pattern_errs(4, 2, 2) != 0 || hold_bad != 0) begin
      errors++; $display("FAIL loop_valid: %0d schedule errs, %0d hold errs, expected 0", pattern_errs(4, 2, 2), hold_bad);
    end
    checks++;
    if (sent_q.size() != 8 || data_errs(2'd0) != 0) begin
      errors++; $display("FAIL loop_data: %0d beats %0d bad, expected 8 beats 0 bad", sent_q.size(), data_errs(2'd0));
    end
    checks++;
    if (rx_count !== 16'd16 || err_count !== 16'd0 || timeout !== 1'b0 || mismatch_ch !== 2'b00) begin
      errors++; $display("FAIL loop_status: rx=%0d err=%0d to=%b mis=%b expected 16 0 0 00", rx_count, err_count, timeout, mismatch_ch);
    end
  endtask

  task automatic test_delayed_lfsr();
    lb_delay = 3;
    do_run(2'd2, 4, 2, 2, 300, -1);
    checks++;
    if (!run_done || busy_cycles >= 255) begin
      errors++; $display("FAIL lfsr_drain: done=%b busy_cycles=%0d expected done on count", run_done, busy_cycles);
    end
    checks++;
    if (sent_q.size() != 8 || data_errs(2'd2) != 0) begin
      errors++; $display("FAIL lfsr_data: %0d beats %0d bad, expected 8 beats 0 bad", sent_q.size(), data_errs(2'd2));
    end
    checks++;
    if (rx_count !== 16'd16 || err_count !== 16'd0 || timeout !== 1'b0) begin
      errors++; $display("FAIL lfsr_status: rx=%0d err=%0d to=%b expected 16 0 0", rx_count, err_count, timeout);
    end
    lb_delay = 0;
  endtask

  task automatic test_force_bit();
    force_mask = 16'h0100;
    do_run(2'd0, 4, 2, 1, 300, -1);
    checks++;
    if (!run_done || err_count !== 16'd2 || mismatch_ch !== 2'b10 || rx_count !== 16'd8) begin
      errors++; $display("FAIL force_bit: done=%b err=%0d mis=%b rx=%0d expected 1 2 10 8", run_done, err_count, mismatch_ch, rx_count);
    end
    force_mask = 16'h0000;
  endtask

  task automatic test_zero_bursts();
    do_run(2'd0, 5, 0, 0, 20, -1);
    checks++;
    if (!run_done || vpat.size() != 1 || sent_q.size() != 0) begin
      errors++; $display("FAIL zero_bursts: done=%b after %0d cycles with %0d beats, expected done at 1 with 0", run_done, vpat.size(), sent_q.size());
    end
    checks++;
    if (err_count !== 16'd0 || rx_count !== 16'd0 || mismatch_ch !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_clear: err=%0d rx=%0d mis=%b busy=%b expected cleared", err_count, rx_count, mismatch_ch, busy);
    end
  endtask

  task automatic test_timeout();
    lb_en = 0;
    do_run(2'd0, 3, 0, 1, 400, -1);
    checks++;
    if (!run_done || busy_cycles != 258) begin
      errors++; $display("FAIL timeout_len: done=%b busy_cycles=%0d expected 1 258", run_done, busy_cycles);
    end
    checks++;
    if (timeout !== 1'b1 || rx_count !== 16'd0 || err_count !== 16'd0) begin
      errors++; $display("FAIL timeout_status: to=%b rx=%0d err=%0d expected 1 0 0", timeout, rx_count, err_count);
    end
    lb_en = 1;
  endtask

  task automatic test_busy_start();
    do_run(2'd0, 4, 1, 2, 300, 3);
    checks++;
    if (!run_done || pattern_errs(4, 1, 2) != 0 || data_errs(2'd0) != 0 || sent_q.size() != 8) begin
      errors++; $display("FAIL busy_start: done=%b sched_errs=%0d data_errs=%0d beats=%0d expected 1 0 0 8",
                         run_done, pattern_errs(4, 1, 2), data_errs(2'd0), sent_q.size());
    end
    checks++;
    if (rx_count !== 16'd16 || timeout !== 1'b0) begin
      errors++; $display("FAIL busy_start_rx: rx=%0d to=%b expected 16 0", rx_count, timeout);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk_2f);
    mode = 2'd0; burst_len = 8'd10; gap_len = 8'd0; num_bursts = 8'd2; start = 1'b1;
    @(negedge clk_2f);
    start = 1'b0;
    repeat (2) @(negedge clk_2f);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (valid_out !== 2'b00 || busy !== 1'b0 || data_out !== 16'h0000 || rx_count !== 16'd0) begin
      errors++; $display("FAIL reset_mid: valid=%b busy=%b data=%h rx=%0d expected 00 0 0000 0", valid_out, busy, data_out, rx_count);
    end
    @(negedge clk_2f);
    reset = 1'b0;
    repeat (3) @(negedge clk_2f);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || valid_out !== 2'b00) begin
      errors++; $display("FAIL reset_wait: busy=%b done=%b valid=%b expected 0 0 00", busy, done, valid_out);
    end
    do_run(2'd0, 2, 0, 1, 100, -1);
    checks++;
    if (sent_q.size() == 0 || sent_q[0] !== 16'h0100) begin
      errors++; $display("FAIL reset_restart: first beat %h (beats=%0d) expected 0100", (sent_q.size() > 0) ? sent_q[0] : 16'hxxxx, sent_q.size());
    end
  endtask

  task automatic test_random();
    logic [1:0] m;
    int bl, gl, nb;
    for (int it = 0; it < 5; it++) begin
      m  = 2'($urandom_range(0, 3));
      bl = $urandom_range(1, 5);
      gl = $urandom_range(0, 3);
      nb = $urandom_range(1, 3);
      lb_delay = $urandom_range(0, 3);
      do_run(m, bl, gl, nb, 600, -1);
      checks++;
      if (!run_done || pattern_errs(bl, gl, nb) != 0 || hold_bad != 0) begin
        errors++; $display("FAIL rand_sched[%0d]: m=%0d bl=%0d gl=%0d nb=%0d done=%b sched_errs=%0d hold=%0d expected 1 0 0",
                           it, m, bl, gl, nb, run_done, pattern_errs(bl, gl, nb), hold_bad);
      end
      checks++;
      if (sent_q.size() != bl * nb || data_errs(m) != 0) begin
        errors++; $display("FAIL rand_data[%0d]: beats=%0d bad=%0d expected %0d 0", it, sent_q.size(), data_errs(m), bl * nb);
      end
      checks++;
      if (rx_count !== 16'(bl * nb * 2) || err_count !== 16'd0 || timeout !== 1'b0) begin
        errors++; $display("FAIL rand_status[%0d]: rx=%0d err=%0d to=%b expected %0d 0 0", it, rx_count, err_count, timeout, bl * nb * 2);
      end
    end
    lb_delay = 0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'd0;
    burst_len = 8'd0; gap_len = 8'd0; num_bursts = 8'd0;
    lb_en = 1; lb_delay = 0; force_mask = 16'h0000;
    test_reset();
    test_loopback_inc();
    test_delayed_lfsr();
    test_force_bit();
    test_zero_bursts();
    test_timeout();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
